// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner.
//   NCODES   : number of select codes walked per scan (A,B,C -> 8 codes)
//   CODE_W   : width of the abc code bus
//   SETTLE_W : width of the settle counter (covers SETTLE up to 15)
//   state_t  : scanner FSM state encoding
package tt_pkg;

   localparam int unsigned NCODES   = 8;
   localparam int unsigned CODE_W   = 3;
   localparam int unsigned SETTLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETTLE = 2'b01,
      ST_SAMPLE = 2'b10,
      ST_DONE   = 2'b11
   } state_t;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// settle_timer: counts the cycles a code has been held on abc.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset (count -> 0)
//   clear  : synchronous clear (count -> 0), wins over enable
//   enable : increment count this cycle
//   tc     : terminal count, high while count == SETTLE-1
module settle_timer
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [SETTLE_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + SETTLE_W'(1);
      end
   end

   assign tc = (count == SETTLE_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks abc through codes 0..7, holds each code for
// SETTLE cycles, samples dut_y on the following cycle, and compares the
// captured table against a reference table latched at start.
//   clk, reset : clock and synchronous active-high reset
//   start      : begin a scan (accepted only in IDLE)
//   expected   : reference table, bit k = required Y for code k
//   dut_y      : output of the mux under test
//   abc        : code driven to the mux (abc[2]=A, abc[1]=B, abc[0]=C)
//   busy       : scan in progress (SETTLE/SAMPLE states)
//   done       : one-cycle pulse when results are valid
//   table_out  : captured truth table
//   match      : table_out == latched expected
//   mismatch   : table_out ^ latched expected
module truth_table_scanner
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [NCODES-1:0] expected,
   input  logic              dut_y,
   output logic [CODE_W-1:0] abc,
   output logic              busy,
   output logic              done,
   output logic [NCODES-1:0] table_out,
   output logic              match,
   output logic [NCODES-1:0] mismatch
);

   localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NCODES - 1);

   state_t            state;
   logic [NCODES-1:0] exp_q;
   logic [NCODES-1:0] table_next;
   logic              accept;
   logic              tmr_clear;
   logic              tmr_enable;
   logic              tmr_tc;

   assign accept     = (state == ST_IDLE) && start;
   assign tmr_clear  = accept || (state == ST_SAMPLE);
   assign tmr_enable = (state == ST_SETTLE);

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .enable (tmr_enable),
      .tc     (tmr_tc)
   );

   // Table with the current sample merged in; used so the final compare
   // sees bit 7 on the same edge that stores it.
   always_comb begin
      table_next      = table_out;
      table_next[abc] = dut_y;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         abc       <= '0;
         table_out <= '0;
         match     <= 1'b0;
         mismatch  <= '0;
         exp_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_SETTLE;
                  abc       <= '0;
                  table_out <= '0;
                  match     <= 1'b0;
                  mismatch  <= '0;
                  exp_q     <= expected;
               end
            end
            ST_SETTLE: begin
               if (tmr_tc) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               table_out <= table_next;
               if (abc == LAST_CODE) begin
                  state    <= ST_DONE;
                  match    <= (table_next == exp_q);
                  mismatch <= table_next ^ exp_q;
               end else begin
                  state <= ST_SETTLE;
                  abc   <= abc + CODE_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (SETTLE = 2, 1, 15), each
// driving a behavioural mux model; results checked against a reference
// computed from the code schedule and the mux function.
module tb_truth_table_scanner;

   logic             clk;
   logic             reset;
   logic [2:0]       start_v;
   logic [2:0][7:0]  exp_v;
   logic [2:0]       y_v;
   logic [2:0][2:0]  abc_v;
   logic [2:0]       busy_v;
   logic [2:0]       done_v;
   logic [2:0][7:0]  table_v;
   logic [2:0]       match_v;
   logic [2:0][7:0]  mm_v;

   int              mode_a [3];
   logic [7:0]      data_a [3];
   int              checks;
   int              errors;

   // mode 0: Y = A&B&C ; mode 1: 8:1 mux over data ; mode 2: Y = A ? B : C
   function automatic logic model_y(input int mode, input logic [7:0] data,
                                    input logic [2:0] code);
      case (mode)
         0:       return code[2] & code[1] & code[0];
         1:       return data[code];
         default: return code[2] ? code[1] : code[0];
      endcase
   endfunction

   function automatic logic [7:0] ref_table(input int mode, input logic [7:0] data);
      logic [7:0] t;
      for (int k = 0; k < 8; k++) t[k] = model_y(mode, data, 3'(k));
      return t;
   endfunction

   function automatic int settle_of(input int idx);
      case (idx)
         0:       return 2;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   assign y_v[0] = model_y(mode_a[0], data_a[0], abc_v[0]);
   assign y_v[1] = model_y(mode_a[1], data_a[1], abc_v[1]);
   assign y_v[2] = model_y(mode_a[2], data_a[2], abc_v[2]);

   truth_table_scanner #(.SETTLE(2)) dut0 (
      .clk(clk), .reset(reset), .start(start_v[0]), .expected(exp_v[0]),
      .dut_y(y_v[0]), .abc(abc_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .table_out(table_v[0]), .match(match_v[0]), .mismatch(mm_v[0]));

   truth_table_scanner #(.SETTLE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start_v[1]), .expected(exp_v[1]),
      .dut_y(y_v[1]), .abc(abc_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .table_out(table_v[1]), .match(match_v[1]), .mismatch(mm_v[1]));

   truth_table_scanner #(.SETTLE(15)) dut2 (
      .clk(clk), .reset(reset), .start(start_v[2]), .expected(exp_v[2]),
      .dut_y(y_v[2]), .abc(abc_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .table_out(table_v[2]), .match(match_v[2]), .mismatch(mm_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int idx, input string tag);
      chk({tag, "_abc"},  32'(abc_v[idx]), 0);
      chk({tag, "_busy"}, 32'(busy_v[idx]), 0);
      chk({tag, "_done"}, 32'(done_v[idx]), 0);
      chk({tag, "_tbl"},  32'(table_v[idx]), 0);
      chk({tag, "_mat"},  32'(match_v[idx]), 0);
      chk({tag, "_mm"},   32'(mm_v[idx]), 0);
   endtask

   // Called at a negedge with the instance idle; returns at the negedge of
   // the cycle after done. Scrambles the expected input mid-scan.
   task automatic scan(input int idx, input int mode, input logic [7:0] data,
                       input logic [7:0] exp_val);
      int s, n;
      logic [7:0] tref;
      s    = settle_of(idx);
      n    = 8 * (s + 1);
      tref = ref_table(mode, data);
      mode_a[idx]  = mode;
      data_a[idx]  = data;
      start_v[idx] = 1'b1;
      exp_v[idx]   = exp_val;
      @(negedge clk);
      start_v[idx] = 1'b0;
      for (int c = 1; c <= n + 2; c++) begin
         if (c <= n) begin
            chk($sformatf("scan%0d_abc_c%0d", idx, c), 32'(abc_v[idx]), 32'((c - 1) / (s + 1)));
            chk($sformatf("scan%0d_busy_c%0d", idx, c), 32'(busy_v[idx]), 1);
            chk($sformatf("scan%0d_done_c%0d", idx, c), 32'(done_v[idx]), 0);
         end else begin
            chk($sformatf("scan%0d_done_c%0d", idx, c), 32'(done_v[idx]), (c == n + 1) ? 1 : 0);
            chk($sformatf("scan%0d_busy_c%0d", idx, c), 32'(busy_v[idx]), 0);
            chk($sformatf("scan%0d_abc_c%0d", idx, c), 32'(abc_v[idx]), 7);
            chk($sformatf("scan%0d_tbl", idx), 32'(table_v[idx]), 32'(tref));
            chk($sformatf("scan%0d_match", idx), 32'(match_v[idx]), (tref == exp_val) ? 1 : 0);
            chk($sformatf("scan%0d_mm", idx), 32'(mm_v[idx]), 32'(tref ^ exp_val));
         end
         if (c == n / 2) exp_v[idx] = ~exp_val;
         if (c < n + 2) @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] d, e;
      bit seen;
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      start_v = '0;
      exp_v   = '0;
      for (int i = 0; i < 3; i++) begin
         mode_a[i] = 0;
         data_a[i] = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) check_idle(i, $sformatf("rst%0d", i));
      reset = 1'b0;
      @(negedge clk);

      // Directed tables: AND gate, 8:1 mux match/mismatch, 2:1 mux.
      scan(0, 0, 8'h00, 8'h80);
      scan(0, 1, 8'b1010_0110, 8'hA6);
      scan(0, 1, 8'b1010_0110, 8'hA7);
      scan(0, 2, 8'h00, 8'hCA);

      // Reset while abc==4, then a full scan.
      mode_a[0]  = 1;
      data_a[0]  = 8'h5B;
      exp_v[0]   = 8'h5B;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (abc_v[0] == 3'd4) seen = 1;
         else @(negedge clk);
      end
      chk("reach_abc4", 32'(seen), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle(0, "midrst");
      scan(0, 1, 8'h3C, 8'h3C);

      // Reset together with start: no scan begins.
      reset      = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
      start_v[0] = 1'b0;
      check_idle(0, "rst_start");
      @(negedge clk);
      chk("rst_start_busy2", 32'(busy_v[0]), 0);

      // Start pulses at cycles 5 and 25 are ignored.
      mode_a[0]  = 0;
      exp_v[0]   = 8'h80;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         chk($sformatf("ign_done_c%0d", c), 32'(done_v[0]), (c == 25) ? 1 : 0);
         chk($sformatf("ign_busy_c%0d", c), 32'(busy_v[0]), (c <= 24) ? 1 : 0);
         start_v[0] = (c == 5 || c == 25);
         @(negedge clk);
         start_v[0] = 1'b0;
      end

      // Start held high: back-to-back scans, dones at 25 and 51.
      start_v[0] = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 52; c++) begin
         chk($sformatf("b2b_done_c%0d", c), 32'(done_v[0]), (c == 25 || c == 51) ? 1 : 0);
         chk($sformatf("b2b_busy_c%0d", c), 32'(busy_v[0]),
             ((c >= 1 && c <= 24) || (c >= 27 && c <= 50)) ? 1 : 0);
         if (c == 51) start_v[0] = 1'b0;
         @(negedge clk);
      end
      chk("b2b_match", 32'(match_v[0]), 1);
      repeat (2) @(negedge clk);

      // Randomized 8:1 tables, about half with a matching reference.
      for (int r = 0; r < 6; r++) begin
         d = 8'($urandom);
         e = ($urandom_range(0, 1) == 1) ? d : 8'($urandom);
         scan(0, 1, d, e);
      end

      // Other settle depths.
      d = 8'($urandom);
      scan(1, 1, d, d);
      d = 8'($urandom);
      scan(1, 2, d, 8'hCA);
      d = 8'($urandom);
      scan(2, 1, d, d ^ 8'h10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
